// File: rtl/control_sequencer.sv
// Instruction sequencer: fetch, multi-cycle execute with memory wait states,
// interrupt entry and halt.
module control_sequencer #(
  parameter int INSTR_W  = 16,
  parameter int OPC_W    = 6,
  parameter int EXEC_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  input  logic               irq,
  input  logic               int_en,
  output logic [1:0]         state,
  output logic [2:0]         exec_cnt,
  output logic               ir_en,
  output logic               pc_cnt_en,
  output logic               pc_sload,
  output logic               sm_extra,
  output logic               irq_ack,
  output logic               halted,
  output logic [OPC_W-1:0]   decoder_opcode
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b10,
    IRQ   = 2'b01,
    HALT  = 2'b11
  } state_e;

  localparam logic [2:0] ExecMax = 3'(EXEC_MAX);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] ir_q;
  logic [3:0]         cls;
  logic [2:0]         lenRaw, execLen;
  logic               isStp, lastCycle, takeIrq;
  logic               unusedIrBits;

  assign cls   = ir_q[INSTR_W-1 -: 4];
  assign isStp = (cls == 4'hF) && (ir_q[INSTR_W-5 -: 7] == 7'd0) && ir_q[INSTR_W-12];
  assign takeIrq = irq && int_en;
  assign unusedIrBits = ^ir_q[INSTR_W-13:0];

  always_comb begin
    case (cls)
      4'b1110: lenRaw = 3'd2;
      4'b1101: lenRaw = 3'd3;
      4'b0110: lenRaw = 3'd2;
      default: lenRaw = 3'd1;
    endcase
    execLen = (lenRaw > ExecMax) ? ExecMax : lenRaw;
  end

  assign lastCycle = (state_q == EXEC) && (cnt_q == execLen);

  // The first execute cycle never waits; later ones stall until memory is ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          state_d = EXEC;
          cnt_d   = 3'd1;
        end
      end
      EXEC: begin
        if ((cnt_q == 3'd1) || mem_ready) begin
          if (cnt_q < execLen) begin
            cnt_d = cnt_q + 3'd1;
          end else begin
            cnt_d = 3'd0;
            if (takeIrq)    state_d = IRQ;
            else if (isStp) state_d = HALT;
            else            state_d = FETCH;
          end
        end
      end
      IRQ:     state_d = FETCH;
      HALT:    if (takeIrq) state_d = IRQ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= 3'd0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ir_en) ir_q <= instruction;
    end
  end

  assign state          = state_q;
  assign exec_cnt       = cnt_q;
  assign decoder_opcode = ir_q[INSTR_W-1 -: OPC_W];
  assign ir_en          = (state_q == FETCH) && mem_ready;
  assign pc_cnt_en      = (state_q == FETCH) && mem_ready;
  assign sm_extra       = (state_q == EXEC) && (cnt_q < execLen);
  assign pc_sload       = (state_q == IRQ) || (lastCycle && ((cls == 4'b1100) || (cls == 4'b1101)));
  assign irq_ack        = (state_q == IRQ);
  assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a cycle-level behavioural model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instruction = '0;
  logic        mem_ready = 1'b0;
  logic        irq = 1'b0;
  logic        int_en = 1'b0;
  logic [1:0]  state;
  logic [2:0]  exec_cnt;
  logic        ir_en, pc_cnt_en, pc_sload, sm_extra, irq_ack, halted;
  logic [5:0]  decoder_opcode;

  logic [23:0] instruction2 = '0;
  logic [1:0]  state2;
  logic [2:0]  exec_cnt2;
  logic        ir_en2, pc_cnt_en2, pc_sload2, sm_extra2, irq_ack2, halted2;
  logic [7:0]  decoder_opcode2;

  int vecCount = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .irq(irq), .int_en(int_en), .state(state), .exec_cnt(exec_cnt),
    .ir_en(ir_en), .pc_cnt_en(pc_cnt_en), .pc_sload(pc_sload), .sm_extra(sm_extra),
    .irq_ack(irq_ack), .halted(halted), .decoder_opcode(decoder_opcode)
  );

  control_sequencer #(.INSTR_W(24), .OPC_W(8), .EXEC_MAX(2)) dut2 (
    .clk(clk), .reset(reset), .instruction(instruction2), .mem_ready(mem_ready),
    .irq(1'b0), .int_en(1'b0), .state(state2), .exec_cnt(exec_cnt2),
    .ir_en(ir_en2), .pc_cnt_en(pc_cnt_en2), .pc_sload(pc_sload2), .sm_extra(sm_extra2),
    .irq_ack(irq_ack2), .halted(halted2), .decoder_opcode(decoder_opcode2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: what the sequencer is doing, as a phase plus step.
  localparam int M_FETCH = 0, M_EXEC = 1, M_IRQ = 2, M_HALT = 3;
  int          mMode = M_FETCH;
  int          mStep = 0;
  logic [15:0] mInstr = '0;
  bit          mValid = 0;

  function automatic int execLen(input logic [15:0] w);
    int n;
    case (int'(w[15:12]))
      14:      n = 2;
      13:      n = 3;
      6:       n = 2;
      default: n = 1;
    endcase
    return (n > 3) ? 3 : n;
  endfunction

  function automatic bit isStop(input logic [15:0] w);
    return (w[15:12] == 4'hF) && (w[11:5] == 7'd0) && w[4];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mMode = M_FETCH; mStep = 0; mInstr = '0; mValid = 1;
    end else begin
      case (mMode)
        M_FETCH: if (mem_ready) begin mInstr = instruction; mMode = M_EXEC; mStep = 1; end
        M_EXEC: if (mStep == 1 || mem_ready) begin
          if (mStep < execLen(mInstr)) mStep++;
          else begin
            mStep = 0;
            mMode = (irq && int_en) ? M_IRQ : (isStop(mInstr) ? M_HALT : M_FETCH);
          end
        end
        M_IRQ:   mMode = M_FETCH;
        default: if (irq && int_en) mMode = M_IRQ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      automatic int  len  = execLen(mInstr);
      automatic int  cls  = int'(mInstr[15:12]);
      automatic bit  inEx = (mMode == M_EXEC);
      automatic logic [1:0] es = (mMode == M_FETCH) ? 2'b00 : (mMode == M_EXEC) ? 2'b10 :
                                 (mMode == M_IRQ) ? 2'b01 : 2'b11;
      checkOutput("state", 32'(state), 32'(es));
      checkOutput("exec_cnt", 32'(exec_cnt), 32'(mStep));
      checkOutput("ir_en", 32'(ir_en), 32'(mMode == M_FETCH && mem_ready));
      checkOutput("pc_cnt_en", 32'(pc_cnt_en), 32'(mMode == M_FETCH && mem_ready));
      checkOutput("sm_extra", 32'(sm_extra), 32'(inEx && mStep < len));
      checkOutput("pc_sload", 32'(pc_sload),
                  32'(mMode == M_IRQ || (inEx && mStep == len && (cls == 12 || cls == 13))));
      checkOutput("irq_ack", 32'(irq_ack), 32'(mMode == M_IRQ));
      checkOutput("halted", 32'(halted), 32'(mMode == M_HALT));
      checkOutput("decoder_opcode", 32'(decoder_opcode), 32'(mInstr[15:10]));
    end
  end

  // One clock cycle: inputs change just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic [15:0] ins, input logic mr, input logic rq,
                               input logic ie, input logic rst);
    @(posedge clk);
    #1;
    instruction = ins; mem_ready = mr; irq = rq; int_en = ie; reset = rst;
    @(negedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(16'h0000, 0, 0, 0, 1);
    applyStimulus(16'h0000, 1, 0, 0, 1);
    checkOutput("rst_state", 32'(state), 32'h0);
    checkOutput("rst_cnt", 32'(exec_cnt), 32'h0);
    checkOutput("rst_opc", 32'(decoder_opcode), 32'h0);
    checkOutput("rst_ir_en", 32'(ir_en), 32'h1);

    // Single-cycle class 0100
    applyStimulus(16'h4C00, 1, 0, 0, 0);
    checkOutput("a_ir_en", 32'(ir_en), 32'h1);
    applyStimulus(16'h4C00, 1, 0, 0, 0);
    checkOutput("a_state", 32'(state), 32'h2);
    checkOutput("a_cnt", 32'(exec_cnt), 32'h1);
    checkOutput("a_opc", 32'(decoder_opcode), 32'h13);
    checkOutput("a_extra", 32'(sm_extra), 32'h0);
    applyStimulus(16'h4C00, 0, 0, 0, 0);
    checkOutput("a_back", 32'(state), 32'h0);

    // lda with two wait states in EXEC(2)
    applyStimulus(16'hE123, 1, 0, 0, 0);
    applyStimulus(16'hE123, 1, 0, 0, 0);
    checkOutput("b_extra1", 32'(sm_extra), 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'hE123, (i == 2), 0, 0, 0);
      checkOutput("b_wait_cnt", 32'(exec_cnt), 32'h2);
      checkOutput("b_wait_extra", 32'(sm_extra), 32'h0);
    end
    applyStimulus(16'hE123, 0, 0, 0, 0);
    checkOutput("b_back", 32'(state), 32'h0);

    // STP, masked irq ignored in HALT, then enabled irq leaves HALT
    applyStimulus(16'hF010, 1, 0, 0, 0);
    applyStimulus(16'hF010, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(16'hF010, 0, 1, 0, 0);
    checkOutput("c_halted", 32'(halted), 32'h1);
    checkOutput("c_state", 32'(state), 32'h3);
    applyStimulus(16'hF010, 0, 1, 1, 0);
    applyStimulus(16'hF010, 0, 0, 0, 0);
    checkOutput("c_irq_state", 32'(state), 32'h1);
    checkOutput("c_irq_ack", 32'(irq_ack), 32'h1);
    applyStimulus(16'hF010, 0, 0, 0, 0);
    checkOutput("c_fetch", 32'(state), 32'h0);

    // call with irq raised mid-instruction
    applyStimulus(16'hD000, 1, 0, 0, 0);
    applyStimulus(16'hD000, 1, 1, 1, 0);
    applyStimulus(16'hD000, 1, 1, 1, 0);
    applyStimulus(16'hD000, 1, 1, 1, 0);
    checkOutput("d_cnt3", 32'(exec_cnt), 32'h3);
    checkOutput("d_sload3", 32'(pc_sload), 32'h1);
    applyStimulus(16'hD000, 0, 0, 0, 0);
    checkOutput("d_irq", 32'(state), 32'h1);
    checkOutput("d_sload_irq", 32'(pc_sload), 32'h1);
    applyStimulus(16'hD000, 0, 0, 0, 0);
    checkOutput("d_fetch", 32'(state), 32'h0);

    // irq beats STP at the last exec cycle
    applyStimulus(16'hF010, 1, 1, 1, 0);
    applyStimulus(16'hF010, 1, 1, 1, 0);
    applyStimulus(16'hF010, 0, 0, 0, 0);
    checkOutput("p_irq", 32'(state), 32'h1);
    applyStimulus(16'h0000, 0, 0, 0, 0);

    // jump: single cycle with pc_sload
    applyStimulus(16'hC000, 1, 0, 0, 0);
    applyStimulus(16'hC000, 0, 0, 0, 0);
    checkOutput("j_sload", 32'(pc_sload), 32'h1);
    applyStimulus(16'hC000, 0, 0, 0, 0);

    // reset during EXEC(2) wait
    applyStimulus(16'h6800, 1, 0, 0, 0);
    applyStimulus(16'h6800, 0, 0, 0, 0);
    applyStimulus(16'h6800, 0, 0, 0, 0);
    checkOutput("e_cnt2", 32'(exec_cnt), 32'h2);
    applyStimulus(16'h6800, 0, 0, 0, 1);
    applyStimulus(16'h6800, 0, 0, 0, 0);
    checkOutput("e_state", 32'(state), 32'h0);
    checkOutput("e_cnt", 32'(exec_cnt), 32'h0);
    checkOutput("e_opc", 32'(decoder_opcode), 32'h0);

    // reset out of HALT
    applyStimulus(16'hF010, 1, 0, 0, 0);
    applyStimulus(16'hF010, 0, 0, 0, 0);
    applyStimulus(16'hF010, 0, 0, 0, 0);
    checkOutput("h_halted", 32'(halted), 32'h1);
    applyStimulus(16'hF010, 0, 0, 0, 1);
    applyStimulus(16'h0000, 0, 0, 0, 0);
    checkOutput("h_state", 32'(state), 32'h0);

    // 24-bit instance: call length clamped to EXEC_MAX=2
    instruction2 = 24'hD00000;
    applyStimulus(16'h0000, 0, 0, 0, 1);
    applyStimulus(16'h0000, 1, 0, 0, 0);
    checkOutput("w_ir_en", 32'(ir_en2), 32'h1);
    applyStimulus(16'h0000, 0, 0, 0, 0);
    checkOutput("w_state1", 32'(state2), 32'h2);
    checkOutput("w_opc", 32'(decoder_opcode2), 32'hD0);
    checkOutput("w_extra1", 32'(sm_extra2), 32'h1);
    applyStimulus(16'h0000, 1, 0, 0, 0);
    checkOutput("w_cnt2", 32'(exec_cnt2), 32'h2);
    checkOutput("w_extra2", 32'(sm_extra2), 32'h0);
    checkOutput("w_sload2", 32'(pc_sload2), 32'h1);
    applyStimulus(16'h0000, 0, 0, 0, 0);
    checkOutput("w_fetch", 32'(state2), 32'h0);
    checkOutput("w_cnt0", 32'(exec_cnt2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
